// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL style memory responder.
// Accepts PutFullData / PutPartialData / Get requests on the A channel, applies
// them to a small word-addressed memory, and returns one response per request
// on the D channel through an in-order response queue.
module tl_ul_mem_responder #(
    parameter int DEPTH  = 16,  // number of 32-bit words, power of two (2..256)
    parameter int SRC_W  = 4,   // source ID width
    parameter int QDEPTH = 2    // response queue entries
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [SRC_W-1:0] a_source,
    input  logic [31:0]      a_address,
    input  logic [3:0]       a_mask,
    input  logic [31:0]      a_data,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [SRC_W-1:0] d_source,
    output logic [31:0]      d_data,
    output logic             d_denied
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    // Memory words; kept in flops because reset must clear every word.
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    // Response queue storage, one field per array.
    logic [2:0]       q_opcode_q [QDEPTH];
    logic [2:0]       q_opcode_d [QDEPTH];
    logic [SRC_W-1:0] q_source_q [QDEPTH];
    logic [SRC_W-1:0] q_source_d [QDEPTH];
    logic [31:0]      q_data_q   [QDEPTH];
    logic [31:0]      q_data_d   [QDEPTH];
    logic             q_denied_q [QDEPTH];
    logic             q_denied_d [QDEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          push;
    logic          pop;
    logic          is_get;
    logic          is_put;
    logic          req_denied;
    logic          mem_wr;
    logic [AW-1:0] word_idx;
    logic [3:0]    wr_mask;
    logic [2:0]    rsp_opcode;
    logic [31:0]   rsp_data;

    // a_ready depends only on queue occupancy, so there is no d_ready -> a_ready path.
    assign a_ready = (count_q != CW'(QDEPTH));
    assign d_valid = (count_q != '0);

    // The head entry drives the D channel directly, so it holds while stalled.
    assign d_opcode = q_opcode_q[rd_ptr_q];
    assign d_source = q_source_q[rd_ptr_q];
    assign d_data   = q_data_q[rd_ptr_q];
    assign d_denied = q_denied_q[rd_ptr_q];

    // Request decode: legality check, write enables and the response to enqueue.
    always_comb begin
        push     = a_valid && a_ready;
        pop      = d_valid && d_ready;
        word_idx = a_address[AW+1:2];
        is_get   = (a_opcode == OP_GET);
        is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
        req_denied = !(is_get || is_put)
                  || (a_address[1:0] != 2'b00)
                  || (a_address[31:2] >= 30'(DEPTH));
        wr_mask  = (a_opcode == OP_PUT_FULL) ? 4'hF : a_mask;
        mem_wr   = push && is_put && !req_denied;
        // Denied Gets still answer with AccessAckData so the requester sees the expected type.
        rsp_opcode = is_get ? OP_ACK_DATA : OP_ACK;
        rsp_data   = (is_get && !req_denied) ? mem_q[word_idx] : 32'h0;
    end

    // Byte-masked memory update for accepted, legal Puts.
    always_comb begin
        mem_d = mem_q;
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem_d[word_idx][8*b +: 8] = a_data[8*b +: 8];
                end
            end
        end
    end

    // Memory state register; reset clears all words.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Queue write, pointer wrap (modulo QDEPTH, which need not be a power of two) and occupancy.
    always_comb begin
        q_opcode_d = q_opcode_q;
        q_source_d = q_source_q;
        q_data_d   = q_data_q;
        q_denied_d = q_denied_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            q_opcode_d[wr_ptr_q] = rsp_opcode;
            q_source_d[wr_ptr_q] = a_source;
            q_data_d[wr_ptr_q]   = rsp_data;
            q_denied_d[wr_ptr_q] = req_denied;
            wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset discards all pending responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_opcode_q[i] <= '0;
                q_source_q[i] <= '0;
                q_data_q[i]   <= '0;
                q_denied_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            q_opcode_q <= q_opcode_d;
            q_source_q <= q_source_d;
            q_data_q   <= q_data_d;
            q_denied_q <= q_denied_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule
